alu_mul_complex_pipe: RTL

Pipelined fixed-point complex multiplier: out = in × const, or in × conj(const).
- Successor to the combinational complex multiply used by the QFT twiddle/phase datapath.
- Adds a valid/ready handshake, a fixed 3-cycle latency and per-sample mode bits (conjugate, rounding, saturation).
- Adds an overflow flag.
- Sits between the state-vector amplitude reader and the butterfly/write-back stage; accepts one amplitude per cycle.

---
 rtl/qcm_cplx_pkg.sv | 48 ++++
 rtl/alu_mul_complex_pipe_round_sat.sv | 28 ++
 rtl/alu_mul_complex_pipe.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/qcm_cplx_pkg.sv
// Shared types and helpers for the pipelined complex multiplier.
// Widths, fixed-point scale and the saturate/wrap helper live here.
package qcm_cplx_pkg;

  localparam int complexnum_bit = 24;
  localparam int fp_bit = 22;
  localparam int sample_size = 8;
  localparam int PROD_W = 2 * complexnum_bit;
  localparam int FULL_W = 2 * complexnum_bit + 1;

  localparam logic [complexnum_bit-1:0] FP_ONE =
    complexnum_bit'(1) << fp_bit;

  typedef struct packed {
    logic signed [complexnum_bit-1:0] re;
    logic signed [complexnum_bit-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic conj;
    logic rnd;
    logic sat;
  } mode_t;

  typedef struct packed {
    logic                      ovf;
    logic [complexnum_bit-1:0] val;
  } rs_t;

  // In range iff every bit from the output sign bit upward agrees.
  function automatic rs_t sat_trunc(
    input logic [FULL_W-1:0] full,
    input logic              sat_en
  );
    logic [FULL_W-complexnum_bit:0] hi;
    rs_t r;
    hi = full[FULL_W-1:complexnum_bit-1];
    r.ovf = !((&hi) || !(|hi));
    r.val = full[complexnum_bit-1:0];
    if (r.ovf && sat_en) begin
      r.val = full[FULL_W-1]
        ? {1'b1, {(complexnum_bit-1){1'b0}}}
        : {1'b0, {(complexnum_bit-1){1'b1}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_mul_complex_pipe_round_sat.sv
// Single-component rounding, fixed-point shift and range clamp.
// Purely combinational; the top uses one per real/imag lane.
module cplx_round_sat
  import qcm_cplx_pkg::*;
(
  input  logic signed [FULL_W-1:0]         full_i,
  input  logic                             round_en,
  input  logic                             sat_en,
  output logic        [complexnum_bit-1:0] val_o,
  output logic                             ovf_o
);

  localparam logic signed [FULL_W-1:0] HALF =
    FULL_W'(1) << (fp_bit - 1);

  logic signed [FULL_W-1:0] rnd;
  logic signed [FULL_W-1:0] shr;
  rs_t                      res;

  always_comb begin
    rnd = round_en ? (full_i + HALF) : full_i;
    shr = rnd >>> fp_bit;
    res = sat_trunc(shr, sat_en);
    val_o = res.val;
    ovf_o = res.ovf;
  end

endmodule

// File: rtl/alu_mul_complex_pipe.sv
// Three-stage complex multiply: capture, products, combine/round.
// One global advance enable stalls every stage on backpressure.
module alu_mul_complex_pipe
  import qcm_cplx_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [complexnum_bit-1:0] in_real,
  input  logic [complexnum_bit-1:0] in_imag,
  input  logic [complexnum_bit-1:0] const_real,
  input  logic [complexnum_bit-1:0] const_imag,
  input  logic [sample_size-1:0]    in_tag,
  input  logic                      conj_en,
  input  logic                      round_en,
  input  logic                      sat_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [complexnum_bit-1:0] out_real,
  output logic [complexnum_bit-1:0] out_imag,
  output logic [sample_size-1:0]    out_tag,
  output logic                      out_ovf
);

  logic adv;

  logic                   s1_valid_q, s1_valid_d;
  cplx_t                  s1_x_q, s1_x_d;
  cplx_t                  s1_k_q, s1_k_d;
  logic [sample_size-1:0] s1_tag_q, s1_tag_d;
  mode_t                  s1_mode_q, s1_mode_d;

  logic                     s2_valid_q, s2_valid_d;
  logic signed [PROD_W-1:0] s2_rr_q, s2_rr_d;
  logic signed [PROD_W-1:0] s2_ii_q, s2_ii_d;
  logic signed [PROD_W-1:0] s2_ri_q, s2_ri_d;
  logic signed [PROD_W-1:0] s2_ir_q, s2_ir_d;
  logic [sample_size-1:0]   s2_tag_q, s2_tag_d;
  mode_t                    s2_mode_q, s2_mode_d;

  logic                      s3_valid_q, s3_valid_d;
  logic [complexnum_bit-1:0] s3_re_q, s3_re_d;
  logic [complexnum_bit-1:0] s3_im_q, s3_im_d;
  logic [sample_size-1:0]    s3_tag_q, s3_tag_d;
  logic                      s3_ovf_q, s3_ovf_d;

  logic signed [FULL_W-1:0]  re_full, im_full;
  logic [complexnum_bit-1:0] re_val, im_val;
  logic                      re_ovf, im_ovf;

  assign adv = !s3_valid_q || out_ready;
  assign in_ready = adv;

  // Products are sign-extended by one bit so the sum cannot wrap.
  always_comb begin
    if (s2_mode_q.conj) begin
      re_full = {s2_rr_q[PROD_W-1], s2_rr_q}
              + {s2_ii_q[PROD_W-1], s2_ii_q};
      im_full = {s2_ri_q[PROD_W-1], s2_ri_q}
              - {s2_ir_q[PROD_W-1], s2_ir_q};
    end else begin
      re_full = {s2_rr_q[PROD_W-1], s2_rr_q}
              - {s2_ii_q[PROD_W-1], s2_ii_q};
      im_full = {s2_ri_q[PROD_W-1], s2_ri_q}
              + {s2_ir_q[PROD_W-1], s2_ir_q};
    end
  end

  cplx_round_sat u_rs_re (
    .full_i   (re_full),
    .round_en (s2_mode_q.rnd),
    .sat_en   (s2_mode_q.sat),
    .val_o    (re_val),
    .ovf_o    (re_ovf)
  );

  cplx_round_sat u_rs_im (
    .full_i   (im_full),
    .round_en (s2_mode_q.rnd),
    .sat_en   (s2_mode_q.sat),
    .val_o    (im_val),
    .ovf_o    (im_ovf)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_k_d     = s1_k_q;
    s1_tag_d   = s1_tag_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_rr_d    = s2_rr_q;
    s2_ii_d    = s2_ii_q;
    s2_ri_d    = s2_ri_q;
    s2_ir_d    = s2_ir_q;
    s2_tag_d   = s2_tag_q;
    s2_mode_d  = s2_mode_q;
    s3_valid_d = s3_valid_q;
    s3_re_d    = s3_re_q;
    s3_im_d    = s3_im_q;
    s3_tag_d   = s3_tag_q;
    s3_ovf_d   = s3_ovf_q;
    if (adv) begin
      s1_valid_d    = in_valid;
      s1_x_d.re     = in_real;
      s1_x_d.im     = in_imag;
      s1_k_d.re     = const_real;
      s1_k_d.im     = const_imag;
      s1_tag_d      = in_tag;
      s1_mode_d     = '{conj: conj_en, rnd: round_en, sat: sat_en};
      s2_valid_d    = s1_valid_q;
      s2_rr_d       = s1_k_q.re * s1_x_q.re;
      s2_ii_d       = s1_k_q.im * s1_x_q.im;
      s2_ri_d       = s1_k_q.re * s1_x_q.im;
      s2_ir_d       = s1_k_q.im * s1_x_q.re;
      s2_tag_d      = s1_tag_q;
      s2_mode_d     = s1_mode_q;
      s3_valid_d    = s2_valid_q;
      s3_re_d       = re_val;
      s3_im_d       = im_val;
      s3_tag_d      = s2_tag_q;
      s3_ovf_d      = re_ovf || im_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_k_q     <= '0;
      s1_tag_q   <= '0;
      s1_mode_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_rr_q    <= '0;
      s2_ii_q    <= '0;
      s2_ri_q    <= '0;
      s2_ir_q    <= '0;
      s2_tag_q   <= '0;
      s2_mode_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_re_q    <= '0;
      s3_im_q    <= '0;
      s3_tag_q   <= '0;
      s3_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_k_q     <= s1_k_d;
      s1_tag_q   <= s1_tag_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_rr_q    <= s2_rr_d;
      s2_ii_q    <= s2_ii_d;
      s2_ri_q    <= s2_ri_d;
      s2_ir_q    <= s2_ir_d;
      s2_tag_q   <= s2_tag_d;
      s2_mode_q  <= s2_mode_d;
      s3_valid_q <= s3_valid_d;
      s3_re_q    <= s3_re_d;
      s3_im_q    <= s3_im_d;
      s3_tag_q   <= s3_tag_d;
      s3_ovf_q   <= s3_ovf_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign out_real  = s3_re_q;
  assign out_imag  = s3_im_q;
  assign out_tag   = s3_tag_q;
  assign out_ovf   = s3_ovf_q;

endmodule
